rotation_slicer: RTL and testbench

- Sits directly downstream of the hall-sensor debouncer on the spinning display.
- Consumes the debounced once-per-revolution index pulse and measures the revolution period in clock cycles.
- Divides each revolution into NUM_SLICES equal angular slices and emits the current slice index plus a strobe at each slice start.
- The frame-buffer read path uses these outputs to select which column to light.

---
 rtl/rotation_slicer.sv | 138 +++++++++++++
 tb/tb_rotation_slicer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_slicer.sv
// Revolution period tracker and angular slicer for the spinning display.
// Define ROTATION_SLICER_PHASE_OFFSET_EN to add a per-revolution slice phase offset.
module rotation_slicer #(
  parameter int unsigned NUM_SLICES        = 64,
  parameter int unsigned MAX_PERIOD_CYCLES = 24_000_000,
  parameter int unsigned PERIOD_WIDTH      = $clog2(MAX_PERIOD_CYCLES + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          clean_in,
`ifdef ROTATION_SLICER_PHASE_OFFSET_EN
  input  logic [$clog2(NUM_SLICES)-1:0] phase_offset_in,
`endif
  output logic                          valid_out,
  output logic [PERIOD_WIDTH-1:0]       period_out,
  output logic                          rev_stb_out,
  output logic [$clog2(NUM_SLICES)-1:0] slice_idx_out,
  output logic                          slice_stb_out
);

  localparam int unsigned IDX_W = $clog2(NUM_SLICES);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = PERIOD_WIDTH'(MAX_PERIOD_CYCLES);

  logic [1:0]              state_q, state_d;
  logic                    prev_clean_q, prev_clean_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] slice_len_q, slice_len_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        off_q, off_d;
  logic                    valid_q, valid_d;
  logic                    rev_stb_q, rev_stb_d;
  logic                    slice_stb_q, slice_stb_d;

  logic                    rise;
  logic [PERIOD_WIDTH-1:0] len_raw;
  logic [PERIOD_WIDTH-1:0] len_new;
  logic [IDX_W-1:0]        offset_in;

`ifdef ROTATION_SLICER_PHASE_OFFSET_EN
  assign offset_in = phase_offset_in;
`else
  assign offset_in = '0;
`endif

  always_comb begin
    rise         = clean_in & ~prev_clean_q;
    prev_clean_d = clean_in;
    cnt_d        = rise ? PERIOD_WIDTH'(1)
                 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_WIDTH'(1));
    // Power-of-two slice count: length is a shift; remainder lands in the last slice.
    len_raw      = cnt_q >> IDX_W;
    len_new      = (len_raw == '0) ? PERIOD_WIDTH'(1) : len_raw;

    state_d     = state_q;
    period_d    = period_q;
    slice_len_d = slice_len_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    off_d       = off_q;
    valid_d     = valid_q;
    rev_stb_d   = 1'b0;
    slice_stb_d = 1'b0;

    if (rise) begin
      rev_stb_d = 1'b1;
      if (state_q == ST_IDLE) begin
        state_d = ST_SYNC;
      end else begin
        state_d     = ST_RUN;
        period_d    = cnt_q;
        slice_len_d = len_new;
        timer_d     = '0;
        idx_d       = '0;
        off_d       = offset_in;
        valid_d     = 1'b1;
        slice_stb_d = 1'b1;
      end
    end else if ((state_q != ST_IDLE) && (cnt_q == CNT_MAX)) begin
      state_d  = ST_IDLE;
      period_d = '0;
      timer_d  = '0;
      idx_d    = '0;
      off_d    = '0;
      valid_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (timer_q == slice_len_q - PERIOD_WIDTH'(1)) begin
        timer_d = '0;
        // Last slice holds until the next index pulse; no wrap.
        if (idx_q != '1) begin
          idx_d       = idx_q + IDX_W'(1);
          slice_stb_d = 1'b1;
        end
      end else begin
        timer_d = timer_q + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      prev_clean_q <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      slice_len_q  <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      valid_q      <= 1'b0;
      rev_stb_q    <= 1'b0;
      slice_stb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_clean_q <= prev_clean_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      slice_len_q  <= slice_len_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      valid_q      <= valid_d;
      rev_stb_q    <= rev_stb_d;
      slice_stb_q  <= slice_stb_d;
    end
  end

  assign valid_out     = valid_q;
  assign period_out    = period_q;
  assign rev_stb_out   = rev_stb_q;
  assign slice_idx_out = idx_q + off_q;
  assign slice_stb_out = slice_stb_q;

endmodule

// File: tb/tb_rotation_slicer.sv
// Self-checking bench for rotation_slicer: directed steps plus randomized revolutions
// checked every cycle against an arithmetic model of slice position.
module tb_rotation_slicer;

  localparam int unsigned NS   = 8;
  localparam int unsigned MAXP = 1000;
  localparam int unsigned PW   = $clog2(MAXP + 1);
  localparam int unsigned IW   = $clog2(NS);

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b0;
  logic          clean_in = 1'b0;
  logic [IW-1:0] phase_offset = '0;
  logic          valid_out;
  logic [PW-1:0] period_out;
  logic          rev_stb_out;
  logic [IW-1:0] slice_idx_out;
  logic          slice_stb_out;

  int vectors = 0;
  int errors  = 0;

  // Reference model: 0 idle, 1 sync, 2 run; position is cycles since last accepted rise.
  int m_state, m_age, m_j, m_len, m_period, m_off;
  bit m_prev;
  int e_rev, e_stb;

  always #5 clk_in = ~clk_in;

  rotation_slicer #(
    .NUM_SLICES(NS),
    .MAX_PERIOD_CYCLES(MAXP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clean_in(clean_in),
`ifdef ROTATION_SLICER_PHASE_OFFSET_EN
    .phase_offset_in(phase_offset),
`endif
    .valid_out(valid_out),
    .period_out(period_out),
    .rev_stb_out(rev_stb_out),
    .slice_idx_out(slice_idx_out),
    .slice_stb_out(slice_stb_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_age = 0; m_j = 0; m_len = 1; m_period = 0; m_off = 0;
    m_prev = 1'b0; e_rev = 0; e_stb = 0;
  endfunction

  function automatic void model_edge(input bit c);
    bit rise;
    int age_b;
    rise  = c && !m_prev;
    age_b = m_age;
    m_prev = c;
    e_rev = 0;
    e_stb = 0;
    m_age = rise ? 1 : ((m_age >= MAXP) ? MAXP : m_age + 1);
    if (rise) begin
      e_rev = 1;
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        m_state  = 2;
        m_period = age_b;
        m_len    = age_b / NS;
        if (m_len < 1) m_len = 1;
        m_j   = 0;
        m_off = phase_offset;
        e_stb = 1;
      end
    end else if (m_state != 0 && age_b == MAXP) begin
      m_state = 0; m_period = 0; m_off = 0;
    end else if (m_state == 2) begin
      m_j++;
      if ((m_j % m_len) == 0 && (m_j / m_len) <= NS - 1) e_stb = 1;
    end
  endfunction

  function automatic int exp_idx();
    int q;
    if (m_state != 2) return 0;
    q = m_j / m_len;
    if (q > NS - 1) q = NS - 1;
    return (q + m_off) % NS;
  endfunction

  task automatic check_all();
    chk("valid", valid_out, (m_state == 2) ? 1 : 0);
    chk("period", period_out, m_period);
    chk("rev_stb", rev_stb_out, e_rev);
    chk("slice_idx", slice_idx_out, exp_idx());
    chk("slice_stb", slice_stb_out, e_stb);
  endtask

  task automatic step(input bit c);
    clean_in = c;
    @(posedge clk_in);
    model_edge(c);
    #1;
    check_all();
  endtask

  task automatic rev(input int p, input int w);
    repeat (w) step(1'b1);
    repeat (p - w) step(1'b0);
  endtask

  initial begin
    int p, w;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all();
    @(negedge clk_in);
    rst_in = 1'b1;

    // Get the DUT tracking, then hit it with a mid-cycle reset.
    repeat (4) rev(20, 1);
    chk("pre_rst_valid", valid_out, 1);
    clean_in = 1'b0;
    @(posedge clk_in);
    model_edge(1'b0);
    #3 rst_in = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_period", period_out, 0);
    chk("arst_idx", slice_idx_out, 0);
    chk("arst_rev", rev_stb_out, 0);
    chk("arst_stb", slice_stb_out, 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    step(1'b0);
    chk("idle_valid", valid_out, 0);

    // Steady rotation at 800 cycles.
    rev(800, 1);
    step(1'b1);
    chk("p800_period", period_out, 800);
    chk("p800_valid", valid_out, 1);
    chk("p800_rev", rev_stb_out, 1);
    repeat (99) step(1'b0);
    chk("p800_idx0_end", slice_idx_out, 0);
    step(1'b0);
    chk("p800_idx1", slice_idx_out, 1);
    chk("p800_stb1", slice_stb_out, 1);
    repeat (699) step(1'b0);
    repeat (2) rev(800, 2);

    // Non-divisible period 803: last slice absorbs the remainder.
    rev(803, 1);
    step(1'b1);
    repeat (700) step(1'b0);
    chk("p803_idx7", slice_idx_out, 7);
    repeat (102) step(1'b0);
    chk("p803_hold7", slice_idx_out, 7);
    chk("p803_hold_nostb", slice_stb_out, 0);
    step(1'b1);
    chk("p803_period", period_out, 803);
    chk("p803_wrap_idx", slice_idx_out, 0);
    chk("p803_wrap_stb", slice_stb_out, 1);

    // Stall timeout.
    repeat (999) step(1'b0);
    chk("stall_before", valid_out, 1);
    step(1'b0);
    chk("stall_valid", valid_out, 0);
    chk("stall_idx", slice_idx_out, 0);
    chk("stall_period", period_out, 0);
    repeat (50) step(1'b0);
    step(1'b1);
    chk("stall_sync_valid", valid_out, 0);
    chk("stall_sync_rev", rev_stb_out, 1);
    repeat (20) step(1'b0);
    chk("stall_sync_hold", valid_out, 0);

    // Short period 5: slice length clamps to one cycle.
    repeat (3) rev(5, 1);
    step(1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0);
      chk("p5_idx", slice_idx_out, k);
      chk("p5_stb", slice_stb_out, 1);
    end
    step(1'b1);
    chk("p5_period", period_out, 5);
    chk("p5_wrap_idx", slice_idx_out, 0);
    repeat (4) step(1'b0);

`ifdef ROTATION_SLICER_PHASE_OFFSET_EN
    phase_offset = 3'd3;
    repeat (2) rev(800, 1);
    step(1'b1);
    chk("off_first", slice_idx_out, 3);
    repeat (700) step(1'b0);
    chk("off_last", slice_idx_out, 2);
    repeat (99) step(1'b0);
    chk("off_hold", slice_idx_out, 2);
    phase_offset = '0;
`endif

    // Randomized revolutions, including periods beyond the stall limit.
    repeat (12) begin
      p = $urandom_range(1200, 2);
      w = $urandom_range((p > 4) ? 3 : p - 1, 1);
`ifdef ROTATION_SLICER_PHASE_OFFSET_EN
      phase_offset = IW'($urandom);
`endif
      rev(p, w);
    end
    repeat (10) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
